pmem_burst_adapter: RTL and testbench
=====================================

Name: pmem_burst_adapter

Overview:
- Sits directly downstream of the cache hierarchy's physical-memory port.
- Converts one 256-bit line read or write request (pmem_* handshake) into a 4-beat, 64-bit burst transaction on the external burst-memory bus.
- On reads, assembles the returned beats into a line before responding upstream.
- Handles exactly one transaction at a time. No queueing, no reordering.

Parameters:
- LINE_W, 256, cache line width in bits; must equal the pmem_rdata/pmem_wdata width.
- BURST_W, 64, burst beat width in bits.
- BEATS, LINE_W/BURST_W (=4), derived beat count; beat counter width is clog2(BEATS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- pmem_read  in  1  line read request, held by upstream until pmem_resp.
- pmem_write  in  1  line write request, held by upstream until pmem_resp.
- pmem_address  in  32  line address; bits [4:0] are ignored.
- pmem_wdata  in  LINE_W  write line, valid while pmem_write is high.
- pmem_rdata  out  LINE_W  assembled read line, valid when pmem_resp is high.
- pmem_resp  out  1  one-cycle completion pulse.
- burst_read_o  out  1  burst read request.
- burst_write_o  out  1  burst write request.
- burst_address_o  out  32  line-aligned address ({addr[31:5],5'b0}).
- burst_wdata_o  out  BURST_W  current write beat.
- burst_rdata_i  in  BURST_W  read beat, valid with burst_resp_i.
- burst_resp_i  in  1  beat accepted (write) or beat valid (read).

Behaviour:
- Synchronous active-low reset; rst_n low forces the following, regardless of state:
  - State returns to IDLE. This aborts any in-flight burst and discards partial data.
  - Beat counter is 0.
  - All outputs are 0: pmem_resp, burst_read_o, burst_write_o, burst_address_o, burst_wdata_o, pmem_rdata.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - pmem_write high → capture the aligned address and the full wdata line; go to WRITE.
  - Otherwise, pmem_read high → capture the aligned address; go to READ.
  - Write has priority if both requests are high.
- READ:
  - burst_read_o=1; burst_address_o = captured address.
  - Each cycle with burst_resp_i=1, store burst_rdata_i into line slice [cnt*64 +: 64] (beat 0 = bits [63:0]) and increment cnt.
  - Gaps between beats are legal; cnt advances only on burst_resp_i.
  - On the beat where cnt==BEATS-1 and burst_resp_i=1, go to DONE with cnt wrapping to 0. burst_read_o drops in that next cycle.
- WRITE:
  - burst_write_o=1; burst_wdata_o = captured line slice [cnt*64 +: 64].
  - Advances on burst_resp_i exactly as READ does.
  - After the final beat, go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle. pmem_rdata holds the assembled line (after a write, the last read line is unchanged).
  - Return to IDLE. Requests seen during the DONE cycle are ignored, because upstream is still holding the request it just completed.
- pmem_rdata stays stable from DONE until the next read's first beat.
- Latency with back-to-back beats:
  - Request seen in IDLE at cycle 0.
  - Burst request asserted cycles 1–4, beats arrive cycles 1–4.
  - pmem_resp at cycle 5.
  - A new request can be accepted at cycle 6.
- pmem_address/pmem_wdata changes after acceptance have no effect.
- burst_resp_i while in IDLE or DONE is ignored (counter unchanged).
- burst_read_o and burst_write_o are never high together. Both are registered-state decodes with no combinational path from pmem_* inputs.

Decomposition:
- Shared package pmem_burst_pkg:
  - state enum (IDLE, READ, WRITE, DONE);
  - LINE_W, BURST_W, BEATS and OFFSET_BITS=5 constants;
  - line_t (logic [255:0]) and beat_t (logic [63:0]) typedefs.
- One natural sub-module: burst_beat_counter, a modulo-BEATS counter with inc, clr, last outputs and a synchronous active-low reset.
- Line capture/assembly stays in the top module.

Test Plan:
- Read, back-to-back beats: pmem_read, addr 0x0000_1234. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on cycles 1–4 → burst_address_o=0x0000_1220; pmem_resp pulses at cycle 5 only; pmem_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with gaps: pmem_write, addr 0x8000_00FF, wdata beat n = 0xA0+n repeated; burst_resp_i on cycles 2, 5, 6, 9 → burst_wdata_o steps through beats 0→3 only after each resp; burst_address_o=0x8000_00E0; pmem_resp at cycle 10.
- Simultaneous read+write in IDLE → only burst_write_o asserts; write data is sent; read is not serviced until re-requested after pmem_resp.
- Reset mid-read: rst_n low after 2 of 4 beats → next cycle all outputs 0 and state IDLE. A fresh read then completes with only its own 4 beats and no stale data.
- Held request through DONE: upstream keeps pmem_read high for one cycle after pmem_resp → exactly one burst is issued; a second read issued afterward starts cleanly at cnt=0.
- Spurious burst_resp_i in IDLE for 3 cycles, then a read → 4 further beats are required before pmem_resp.

Source files
------------

// File: rtl/pmem_burst_pkg.sv
// Shared types and constants for the cache-line to burst-bus adapter.
// Line/beat geometry lives here so the top and the beat counter agree on it.
package pmem_burst_pkg;

  localparam int LINE_W      = 256;
  localparam int BURST_W     = 64;
  localparam int BEATS       = LINE_W / BURST_W;
  localparam int CNT_W       = $clog2(BEATS);
  localparam int OFFSET_BITS = 5;
  localparam int ADDR_W      = 32;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  // Clears the byte-offset bits so every burst starts on a line boundary.
  function automatic addr_t align_addr(input addr_t addr);
    return addr & ~{{(ADDR_W-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Modulo-N beat counter: counts accepted beats within one burst and flags the
// final beat so the adapter knows when the line transfer is complete.
module burst_beat_counter
  import pmem_burst_pkg::*;
#(
  parameter int N = BEATS,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last_o = (cnt_q == W'(N - 1));
  assign cnt_o  = cnt_q;

  // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned,
  // which is what keeps this block from inferring a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order across blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pmem_burst_adapter.sv
// Converts one 256-bit pmem line request into a 4-beat 64-bit burst and, for
// reads, assembles the returned beats into the line presented upstream.
module pmem_burst_adapter
  import pmem_burst_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [ADDR_W-1:0]  pmem_address,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic               burst_read_o,
  output logic               burst_write_o,
  output logic [ADDR_W-1:0]  burst_address_o,
  output logic [BURST_W-1:0] burst_wdata_o,
  input  logic [BURST_W-1:0] burst_rdata_i,
  input  logic               burst_resp_i
);

  state_t state_q;
  addr_t  addr_q;
  line_t  wline_q;
  line_t  rline_q;

  cnt_t   beat_cnt;
  logic   beat_last;
  logic   beat_inc;
  logic   in_burst;

  assign in_burst = (state_q == READ) || (state_q == WRITE);
  assign beat_inc = burst_resp_i && in_burst;

  burst_beat_counter #(
    .N (BEATS),
    .W (CNT_W)
  ) u_beat_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (beat_inc),
    .clr_i  (state_q == IDLE),
    .cnt_o  (beat_cnt),
    .last_o (beat_last)
  );

  // NOTE: the line registers are reset even though they are wide, because the
  // upstream read line must read as zero after reset, not as stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Write wins when both requests are raised in the same cycle.
          if (pmem_write) begin
            addr_q  <= align_addr(pmem_address);
            wline_q <= pmem_wdata;
            state_q <= WRITE;
          end else if (pmem_read) begin
            addr_q  <= align_addr(pmem_address);
            state_q <= READ;
          end
        end
        READ: begin
          if (burst_resp_i) begin
            rline_q[beat_cnt*BURST_W +: BURST_W] <= burst_rdata_i;
            if (beat_last) begin
              state_q <= DONE;
            end
          end
        end
        WRITE: begin
          if (burst_resp_i && beat_last) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // Upstream still holds the request it just completed; ignore it.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode registered state only; nothing flows through from pmem_*.
  assign burst_read_o    = (state_q == READ);
  assign burst_write_o   = (state_q == WRITE);
  assign pmem_resp       = (state_q == DONE);
  assign burst_address_o = addr_q;
  assign burst_wdata_o   = (state_q == WRITE) ? wline_q[beat_cnt*BURST_W +: BURST_W] : '0;
  assign pmem_rdata      = rline_q;

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Scoreboard bench for pmem_burst_adapter: a behavioural line memory serves and
// absorbs bursts, expected completions are queued at issue and checked on pmem_resp.
module tb_pmem_burst_adapter;
  import pmem_burst_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [31:0]  pmem_address = '0;
  logic [255:0] pmem_wdata = '0;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         burst_read_o;
  logic         burst_write_o;
  logic [31:0]  burst_address_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i = '0;
  logic         burst_resp_i = 1'b0;

  pmem_burst_adapter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .burst_read_o    (burst_read_o),
    .burst_write_o   (burst_write_o),
    .burst_address_o (burst_address_o),
    .burst_wdata_o   (burst_wdata_o),
    .burst_rdata_i   (burst_rdata_i),
    .burst_resp_i    (burst_resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  exp_t         sb_q[$];
  logic [255:0] mem[logic [31:0]];
  logic [255:0] wcap = '0;
  logic [255:0] last_rd = '0;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] al);
    if (!mem.exists(al)) mem[al] = rand_line();
    return mem[al];
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, " pmem_resp"}, pmem_resp, 0);
    check({tag, " burst_read_o"}, burst_read_o, 0);
    check({tag, " burst_write_o"}, burst_write_o, 0);
    check({tag, " burst_address_o"}, burst_address_o, 0);
    check({tag, " burst_wdata_o"}, burst_wdata_o, 0);
    check({tag, " pmem_rdata"}, pmem_rdata, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    burst_resp_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sb_q.delete();
    last_rd = '0;
    check_outputs_zero("reset");
    rst_n = 1'b1;
  endtask

  // Issues one request, plays the burst-memory side beat by beat, and returns
  // the cycle (request cycle = 0) in which pmem_resp was seen.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wdata, input int gap_pct,
                        input logic [15:0] mask, output int lat);
    exp_t         e;
    logic [31:0]  al;
    logic [255:0] src;
    int           beat;
    bit           r;
    al = addr & 32'hFFFF_FFE0;
    e.is_wr = wr;
    e.addr  = al;
    if (wr) begin
      e.line  = wdata;
      mem[al] = wdata;
    end else begin
      e.line = model_line(al);
    end
    src  = e.line;
    wcap = '0;
    beat = 0;
    lat  = -1;
    @(posedge clk); #1;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wdata;
    burst_resp_i = 1'b0;
    sb_q.push_back(e);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        pmem_address = $urandom;
        pmem_wdata   = rand_line();
      end
      burst_rdata_i = {$urandom, $urandom};
      if (pmem_resp) begin
        lat = c;
        burst_resp_i = 1'b0;
        break;
      end
      check("burst_read_o level", burst_read_o, !wr);
      check("burst_write_o level", burst_write_o, wr);
      check("burst_address_o", burst_address_o, al);
      if (wr) check("burst_wdata_o beat", burst_wdata_o, src[beat*64 +: 64]);
      r = (gap_pct < 0) ? (c < 16 && mask[c]) : ($urandom_range(99) >= gap_pct);
      if (beat >= 4) r = 1'b0;
      burst_resp_i = r;
      if (r) begin
        if (!wr) burst_rdata_i = src[beat*64 +: 64];
        else     wcap[beat*64 +: 64] = burst_wdata_o;
        beat++;
      end
    end
    if (lat < 0) begin
      check("pmem_resp within cycle budget", 0, 1);
      apply_reset();
    end else begin
      @(posedge clk); #1;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      check("pmem_resp single pulse", pmem_resp, 0);
      check("no burst after done (rd)", burst_read_o, 0);
      @(posedge clk); #1;
      check("idle burst_read_o", burst_read_o, 0);
      check("idle burst_write_o", burst_write_o, 0);
      check("idle pmem_resp", pmem_resp, 0);
    end
  endtask

  // Monitor: pops the expected completion on every pmem_resp.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && pmem_resp) begin
        if (sb_q.size() == 0) begin
          check("unexpected pmem_resp", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("completion address", burst_address_o, e.addr);
          if (e.is_wr) begin
            check("written line", wcap, e.line);
            check("rdata kept after write", pmem_rdata, last_rd);
          end else begin
            check("read line", pmem_rdata, e.line);
            last_rd = e.line;
          end
        end
      end
    end
  end

  initial begin
    int           lat;
    logic [255:0] wd;
    logic [31:0]  a;
    logic [7:0]   b;
    int           k;

    apply_reset();

    // Back-to-back read with known beats.
    mem[32'h0000_1220] = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    do_txn(1'b1, 1'b0, 32'h0000_1234, '0, 0, '0, lat);
    check("read latency", lat, 5);

    // Write with beats accepted on cycles 2, 5, 6, 9.
    for (int n = 0; n < 4; n++) begin
      b = 8'hA0 + 8'(n);
      wd[n*64 +: 64] = {8{b}};
    end
    do_txn(1'b0, 1'b1, 32'h8000_00FF, wd, -1, 16'b0000_0010_0110_0100, lat);
    check("gapped write latency", lat, 10);

    // Simultaneous read and write: write wins, read serviced once re-requested.
    a  = 32'h0000_4440;
    wd = rand_line();
    do_txn(1'b1, 1'b1, a, wd, 0, '0, lat);
    check("simultaneous latency", lat, 5);
    do_txn(1'b1, 1'b0, a, '0, 0, '0, lat);
    check("read-after-write latency", lat, 5);

    // Reset after two beats of a read, then a clean read.
    a = 32'h0000_7700;
    @(posedge clk); #1;
    pmem_read = 1'b1;
    pmem_address = a;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      burst_resp_i  = 1'b1;
      burst_rdata_i = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    pmem_read = 1'b0;
    burst_resp_i = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("mid-read reset");
    last_rd = '0;
    rst_n = 1'b1;
    do_txn(1'b1, 1'b0, a, '0, 0, '0, lat);
    check("post-reset read latency", lat, 5);
    do_txn(1'b1, 1'b0, a + 32'h20, '0, 0, '0, lat);
    check("second read latency", lat, 5);

    // Spurious burst responses while idle must not advance the beat count.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      burst_resp_i  = 1'b1;
      burst_rdata_i = {$urandom, $urandom};
    end
    do_txn(1'b1, 1'b0, 32'h0000_9990, '0, 0, '0, lat);
    check("read after spurious resp latency", lat, 5);

    // Randomized mix against the line-memory model.
    for (int t = 0; t < 40; t++) begin
      a = 32'h1000_0000 + (32'($urandom_range(3)) << 5) + 32'($urandom_range(31));
      k = $urandom_range(2);
      do_txn(k != 1, k != 0, a, rand_line(), 40, '0, lat);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
